eager_fork: RTL and testbench
=============================

EAGER_FORK -- requirements
Module: eager_fork

Interface
- REQ-001: Parameter NUM_OUTPUTS, default 2; number of consumer branches, legal range 1..16.
- REQ-002: Parameter DATA_WIDTH, default 32; payload width in bits.
- REQ-003: Parameter EAGER, default 1; 1 = eager fork (per-branch independent acceptance), 0 = lazy fork (all branches accept in the same cycle).
- REQ-004: Port clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: Port rst_n  input  1  reset, asynchronous, active-low.
- REQ-006: Port data_in  input  DATA_WIDTH  producer payload.
- REQ-007: Port valid_in  input  1  producer valid.
- REQ-008: Port ready_in  output  1  fork ready to producer.
- REQ-009: Port data_out  output  NUM_OUTPUTS x DATA_WIDTH  per-branch payload.
- REQ-010: Port valid_out  output  NUM_OUTPUTS  per-branch valid.
- REQ-011: Port ready_out  input  NUM_OUTPUTS  per-branch consumer ready.
- REQ-012: Port fork_mask  input  NUM_OUTPUTS  branch enable; 1 = branch participates.
- REQ-013: Port busy  output  1  high while a token is partially delivered (any sent bit set).

Function
- REQ-014: The block SHALL hold a state register sent[NUM_OUTPUTS-1:0] and a mask register mask_q[NUM_OUTPUTS-1:0]; pending = |sent; busy = pending.
- REQ-015: The active mask m SHALL be mask_q when pending, otherwise fork_mask (combinational).
- REQ-016: When not pending, mask_q SHALL load fork_mask every cycle; while pending, mask_q SHALL hold, so mask changes mid-token do not affect the token in flight.
- REQ-017: data_out[i] SHALL equal data_in for every i, combinationally, with zero latency.
- REQ-018: done[i] SHALL be (~m[i]) | sent[i] | ready_out[i].
- REQ-019: ready_in SHALL be the AND of done[i] over all i, independent of valid_in.
- REQ-020: In EAGER=1, valid_out[i] SHALL be valid_in & m[i] & ~sent[i].
- REQ-021: In EAGER=1, on a branch handshake (valid_out[i] & ready_out[i]) without an input handshake, sent[i] SHALL be set at the next edge.
- REQ-022: On an input handshake (valid_in & ready_in), all sent bits SHALL clear at the next edge, taking priority over REQ-021.
- REQ-023: In EAGER=0, sent SHALL stay all-zero; valid_out[i] SHALL be valid_in & m[i] & AND of done[j] over all j != i.
- REQ-024: With m all-zero, ready_in SHALL be 1, every valid_out SHALL be 0, and the token SHALL be consumed (sink behaviour).
- REQ-025: With NUM_OUTPUTS = 1, the block SHALL degenerate to a pass-through: ready_in = ~m[0] | ready_out[0].
- REQ-026: Each enabled branch SHALL receive each token exactly once; no branch SHALL see valid_out asserted again for a token it has already accepted.
- REQ-027: Upstream SHALL keep valid_in high and data_in stable while pending; if valid_in drops while pending, sent and mask_q SHALL hold and all valid_out SHALL be 0 until valid_in returns.
- REQ-028: ready_out SHALL NOT depend combinationally on valid_out, to prevent combinational loops.

Reset
- REQ-029: While rst_n = 0, sent and mask_q SHALL be all-zero asynchronously; busy SHALL be 0, and valid_out SHALL reflect only valid_in & fork_mask.
- REQ-030: Reset asserted mid-token SHALL discard partial delivery; after release, the held token SHALL be re-offered to all enabled branches.
- REQ-031: Release of reset SHALL take effect at the first rising edge of clk after rst_n rises.

Verification
- REQ-032: EAGER=1, N=3, mask=111, ready_out=011, valid_in=1 -> cycle0: valid_out=111, ready_in=0; cycle1: sent=011, valid_out=100, busy=1; set ready_out=100 -> ready_in=1, then sent=000 next cycle.
- REQ-033: Mask change mid-token: mask=11, branch0 accepts, then fork_mask=01 while busy -> branch1 still receives the token (mask_q=11); after completion, mask 01 applies.
- REQ-034: mask=000, valid_in=1, ready_out=000 -> ready_in=1, valid_out=000, tokens sunk every cycle.
- REQ-035: EAGER=0, N=2, mask=11, ready_out=01 -> valid_out[1]=1, valid_out[0]=0, ready_in=0, sent stays 00; ready_out=11 -> both valid, ready_in=1.
- REQ-036: Random back-pressure, 10k tokens, N=4, random mask per token -> each enabled branch receives every token exactly once, in order; a scoreboard counts per-branch deliveries against the mask.
- REQ-037: rst_n pulsed low with sent=01 -> sent=00 immediately (asynchronous); token re-delivered to both branches after release.

Source files
------------

// File: rtl/eager_fork.sv
// Eager/lazy fork: broadcasts one producer token to up to NUM_OUTPUTS consumer
// branches. In eager mode each branch may accept in a different cycle and a
// per-branch "sent" bit remembers who already has the token; in lazy mode all
// enabled branches must accept together. The branch-enable mask is latched
// while a token is partially delivered so it cannot change under that token.
module eager_fork #(
    parameter int NUM_OUTPUTS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int EAGER       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    input  logic                                  valid_in,
    output logic                                  ready_in,
    output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] data_out,
    output logic [NUM_OUTPUTS-1:0]                valid_out,
    input  logic [NUM_OUTPUTS-1:0]                ready_out,
    input  logic [NUM_OUTPUTS-1:0]                fork_mask,
    output logic                                  busy
);

    logic [NUM_OUTPUTS-1:0] sent_q;
    logic [NUM_OUTPUTS-1:0] sent_d;
    logic [NUM_OUTPUTS-1:0] mask_q;
    logic [NUM_OUTPUTS-1:0] mask_d;
    logic [NUM_OUTPUTS-1:0] act_mask;
    logic [NUM_OUTPUTS-1:0] done;
    logic                   pending;
    logic                   in_hs;

    assign pending  = |sent_q;
    assign busy     = pending;
    // A token in flight keeps the mask it started with.
    assign act_mask = pending ? mask_q : fork_mask;
    // A branch is finished if disabled, already served, or accepting now.
    assign done     = ~act_mask | sent_q | ready_out;
    assign ready_in = &done;
    assign in_hs    = valid_in & ready_in;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_branch
            // All branches see the producer payload directly.
            assign data_out[gi] = data_in;
            if (EAGER != 0) begin : g_eager
                // Offer only to enabled branches that have not taken this token.
                assign valid_out[gi] = valid_in & act_mask[gi] & ~sent_q[gi];
            end else begin : g_lazy
                // Offer only when every other branch is able to finish this cycle,
                // so all enabled branches accept together.
                localparam logic [NUM_OUTPUTS-1:0] SELF = NUM_OUTPUTS'(1) << gi;
                assign valid_out[gi] = valid_in & act_mask[gi] & (&(done | SELF));
            end
        end
    endgenerate

    // Next-state for the delivery record: input handshake clears, branch
    // handshakes accumulate (eager mode only; lazy mode never records).
    always_comb begin
        sent_d = sent_q;
        if (in_hs) begin
            sent_d = '0;
        end else if (EAGER != 0) begin
            sent_d = sent_q | (valid_out & ready_out);
        end
    end

    // Mask tracks fork_mask while idle and freezes while a token is partial.
    always_comb begin
        mask_d = pending ? mask_q : fork_mask;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_q <= '0;
            mask_q <= '0;
        end else begin
            sent_q <= sent_d;
            mask_q <= mask_d;
        end
    end

endmodule

// File: tb/tb_eager_fork.sv
// Directed bench for eager_fork: eager N=3, lazy N=2 and pass-through N=1
// instances, plus a short random back-pressure run with a delivery scoreboard.
module tb_eager_fork;

    logic clk;
    logic rst_n;

    // Eager, three branches
    logic [7:0]      d3_in;
    logic            v3_in;
    logic            r3_in;
    logic [2:0][7:0] d3_out;
    logic [2:0]      v3_out;
    logic [2:0]      r3_out;
    logic [2:0]      m3;
    logic            b3;

    // Lazy, two branches
    logic [7:0]      d2_in;
    logic            v2_in;
    logic            r2_in;
    logic [1:0][7:0] d2_out;
    logic [1:0]      v2_out;
    logic [1:0]      r2_out;
    logic [1:0]      m2;
    logic            b2;

    // Single branch
    logic [7:0]      d1_in;
    logic            v1_in;
    logic            r1_in;
    logic [0:0][7:0] d1_out;
    logic [0:0]      v1_out;
    logic [0:0]      r1_out;
    logic [0:0]      m1;
    logic            b1;

    int n_checks = 0;
    int n_errors = 0;

    eager_fork #(.NUM_OUTPUTS(3), .DATA_WIDTH(8), .EAGER(1)) u3 (
        .clk(clk), .rst_n(rst_n), .data_in(d3_in), .valid_in(v3_in), .ready_in(r3_in),
        .data_out(d3_out), .valid_out(v3_out), .ready_out(r3_out), .fork_mask(m3), .busy(b3));

    eager_fork #(.NUM_OUTPUTS(2), .DATA_WIDTH(8), .EAGER(0)) u2 (
        .clk(clk), .rst_n(rst_n), .data_in(d2_in), .valid_in(v2_in), .ready_in(r2_in),
        .data_out(d2_out), .valid_out(v2_out), .ready_out(r2_out), .fork_mask(m2), .busy(b2));

    eager_fork #(.NUM_OUTPUTS(1), .DATA_WIDTH(8), .EAGER(1)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(d1_in), .valid_in(v1_in), .ready_in(r1_in),
        .data_out(d1_out), .valid_out(v1_out), .ready_out(r1_out), .fork_mask(m1), .busy(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (one rising edge in between).
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] m_model;
        logic [2:0] m_hold;
        logic       pend;
        logic [2:0] hs;
        logic [2:0] got1;
        logic       over;
        int         cnt [3];
        int         tokens;

        rst_n = 1'b0;
        d3_in = 8'hA5; v3_in = 1'b1; r3_out = 3'b000; m3 = 3'b101;
        d2_in = 8'h00; v2_in = 1'b0; r2_out = 2'b00;  m2 = 2'b00;
        d1_in = 8'h00; v1_in = 1'b0; r1_out = 1'b0;   m1 = 1'b0;
        #1;
        chk("reset_busy", 32'(b3), 32'h0);
        chk("reset_valid_out", 32'(v3_out), 32'h5);
        chk("reset_ready_in", 32'(r3_in), 32'h0);
        $display("txn reset: busy=%0d valid_out=%b", b3, v3_out);

        // Partial delivery: branches 0,1 accept first, branch 2 later.
        @(negedge clk);
        rst_n = 1'b1; m3 = 3'b111; r3_out = 3'b011;
        #1;
        chk("c0_valid_out", 32'(v3_out), 32'h7);
        chk("c0_ready_in", 32'(r3_in), 32'h0);
        chk("c0_data_out", 32'(d3_out), 32'hA5A5A5);
        tick();
        #1;
        chk("c1_valid_out", 32'(v3_out), 32'h4);
        chk("c1_busy", 32'(b3), 32'h1);
        chk("c1_ready_in_hold", 32'(r3_in), 32'h0);
        r3_out = 3'b100;
        #1;
        chk("c1_ready_in", 32'(r3_in), 32'h1);
        $display("txn partial: valid_out=%b ready_in=%0d", v3_out, r3_in);
        tick();
        v3_in = 1'b0; r3_out = 3'b000;
        #1;
        chk("c2_busy_clear", 32'(b3), 32'h0);

        // Mask change while busy must not affect the token in flight.
        m3 = 3'b011; v3_in = 1'b1; d3_in = 8'h3C; r3_out = 3'b001;
        #1;
        chk("mask_valid_out0", 32'(v3_out), 32'h3);
        chk("mask_ready_in0", 32'(r3_in), 32'h0);
        tick();
        m3 = 3'b001; r3_out = 3'b000;
        #1;
        chk("mask_held_valid_out", 32'(v3_out), 32'h2);
        chk("mask_held_busy", 32'(b3), 32'h1);
        r3_out = 3'b010;
        #1;
        chk("mask_held_ready_in", 32'(r3_in), 32'h1);
        tick();
        v3_in = 1'b0; r3_out = 3'b000;
        #1;
        chk("mask_after_busy", 32'(b3), 32'h0);
        v3_in = 1'b1;
        #1;
        chk("mask_new_valid_out", 32'(v3_out), 32'h1);
        chk("mask_new_ready_in", 32'(r3_in), 32'h0);
        $display("txn mask_change: valid_out=%b", v3_out);

        // valid_in drop while pending: state holds, nothing offered.
        m3 = 3'b011; r3_out = 3'b001; d3_in = 8'h11;
        tick();
        v3_in = 1'b0; r3_out = 3'b000;
        #1;
        chk("drop_valid_out", 32'(v3_out), 32'h0);
        chk("drop_busy", 32'(b3), 32'h1);
        tick();
        #1;
        chk("drop_busy_hold", 32'(b3), 32'h1);
        v3_in = 1'b1;
        #1;
        chk("drop_return_valid_out", 32'(v3_out), 32'h2);
        $display("txn valid_drop: valid_out=%b busy=%0d", v3_out, b3);

        // Asynchronous reset mid-token discards partial delivery.
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", 32'(b3), 32'h0);
        chk("areset_valid_out", 32'(v3_out), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reoffer_valid_out", 32'(v3_out), 32'h3);
        r3_out = 3'b011;
        #1;
        chk("reoffer_ready_in", 32'(r3_in), 32'h1);
        $display("txn async_reset: valid_out=%b ready_in=%0d", v3_out, r3_in);
        tick();
        r3_out = 3'b000;

        // All-zero mask sinks tokens.
        m3 = 3'b000;
        #1;
        chk("sink_ready_in", 32'(r3_in), 32'h1);
        chk("sink_valid_out", 32'(v3_out), 32'h0);
        tick();
        #1;
        chk("sink_busy", 32'(b3), 32'h0);
        chk("sink_ready_in2", 32'(r3_in), 32'h1);
        $display("txn sink: ready_in=%0d valid_out=%b", r3_in, v3_out);

        // Lazy fork, two branches.
        v2_in = 1'b1; m2 = 2'b11; r2_out = 2'b01; d2_in = 8'h77;
        #1;
        chk("lazy_valid_out", 32'(v2_out), 32'h2);
        chk("lazy_ready_in", 32'(r2_in), 32'h0);
        tick();
        #1;
        chk("lazy_busy", 32'(b2), 32'h0);
        chk("lazy_valid_out_hold", 32'(v2_out), 32'h2);
        r2_out = 2'b11;
        #1;
        chk("lazy_both_valid", 32'(v2_out), 32'h3);
        chk("lazy_both_ready_in", 32'(r2_in), 32'h1);
        r2_out = 2'b10;
        #1;
        chk("lazy_sym_valid", 32'(v2_out), 32'h1);
        $display("txn lazy: valid_out=%b ready_in=%0d", v2_out, r2_in);
        v2_in = 1'b0;

        // Single branch degenerates to pass-through.
        v1_in = 1'b1; m1 = 1'b1; r1_out = 1'b0; d1_in = 8'h5A;
        #1;
        chk("n1_ready_in0", 32'(r1_in), 32'h0);
        chk("n1_valid_out", 32'(v1_out), 32'h1);
        r1_out = 1'b1;
        #1;
        chk("n1_ready_in1", 32'(r1_in), 32'h1);
        chk("n1_data_out", 32'(d1_out), 32'h5A);
        m1 = 1'b0; r1_out = 1'b0;
        #1;
        chk("n1_masked_ready", 32'(r1_in), 32'h1);
        chk("n1_masked_valid", 32'(v1_out), 32'h0);
        $display("txn pass_through: ready_in=%0d valid_out=%b", r1_in, v1_out);

        // Random back-pressure with a per-branch delivery scoreboard.
        pend = 1'b0; m_hold = 3'b000; tokens = 0;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            v3_in  = 1'b1;
            d3_in  = 8'(tokens);
            m3     = 3'($urandom_range(0, 7));
            r3_out = 3'($urandom_range(0, 7));
            #1;
            m_model = pend ? m_hold : m3;
            hs = v3_out & r3_out;
            for (int i = 0; i < 3; i++) cnt[i] += int'(hs[i]);
            if (v3_in && r3_in) begin
                over = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    got1[i] = (cnt[i] == 1);
                    if (cnt[i] > 1) over = 1'b1;
                    cnt[i] = 0;
                end
                chk($sformatf("rand_token%0d", tokens), {28'h0, over, got1}, {29'h0, m_model});
                tokens++;
                pend = 1'b0;
            end else if (hs != 3'b000 && !pend) begin
                pend = 1'b1;
                m_hold = m_model;
            end
        end
        chk("rand_token_progress", 32'(tokens > 300), 32'h1);
        $display("txn random: tokens=%0d", tokens);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
